picorv32_sram_bridge: RTL and testbench
=======================================

Name: picorv32_sram_bridge

Overview:
- Parametrised bridge between the picorv32 native memory interface and one or more single-port SRAM macros with active-low controls (sky130 style).
- Replaces the fixed "ready one cycle after valid" stub used in the core wrappers.
- Supports configurable bank count, words per bank, read latency and base address.
- Out-of-range accesses complete immediately with an error flag, so the core never hangs.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address of the SRAM window (aligned to the window size).
- NUM_BANKS, 2: number of SRAM macros; power of two, 1..8.
- BANK_AW, 8: word-address width per bank (2^BANK_AW 32-bit words per bank).
- READ_LATENCY, 1: number of cycles from the chip-select-low cycle to valid sram_dout; range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_valid  in  1  core request valid
- mem_instr  in  1  instruction fetch (informational; ignored)
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- sram_csb  out  NUM_BANKS  per-bank chip select, active low
- sram_web  out  1  write enable, active low
- sram_wmask  out  4  byte mask
- sram_addr  out  BANK_AW  word address within bank
- sram_din  out  32  write data
- sram_dout  in  NUM_BANKS*32  per-bank read data; bank b occupies bits [32b+31:32b]
- err  out  1  sticky out-of-range flag
- err_addr  out  32  address of the first out-of-range access

Behaviour:
- Decode:
  - off = mem_addr - BASE_ADDR (32-bit).
  - In range iff mem_addr >= BASE_ADDR and off < NUM_BANKS*4*2^BANK_AW.
  - word = off[31:2]; sram_addr = word[BANK_AW-1:0]; bank = word[BANK_AW +: log2(NUM_BANKS)] (0 if NUM_BANKS=1).
  - mem_addr[1:0] are ignored.
- Reset values:
  - state=IDLE, mem_ready=0, mem_rdata=0.
  - sram_csb all 1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
  - err=0, err_addr=0.
  - Reset asserted mid-transaction aborts it: no mem_ready pulse, csb returns high on the next edge.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if mem_valid and not mem_ready, latch the request.
    - In range: next state ISSUE. Drive sram_csb[bank]=0, sram_web=~|mem_wstrb, sram_wmask=mem_wstrb, sram_addr, sram_din=mem_wdata.
    - Out of range: next state RESP. Set mem_ready=1 and mem_rdata=0. If err=0, set err=1 and err_addr=mem_addr.
  - ISSUE (csb low this cycle): next edge returns csb all 1 and web=1.
    - Write: mem_ready=1 next edge, go to RESP.
    - Read: load counter=READ_LATENCY-1, go to WAIT.
  - WAIT: decrement the counter. When counter==0, capture mem_rdata=sram_dout[latched bank], set mem_ready=1 and go to RESP.
  - RESP: mem_ready clears at the next edge; go to IDLE.
- Latency from the accept edge (cycle 0 = first cycle mem_valid is seen in IDLE) to the mem_ready-high cycle:
  - write: 2
  - read: 2+READ_LATENCY
  - out-of-range: 1
- mem_ready is exactly one cycle wide.
- A new request is never accepted in the RESP cycle. Back-to-back requests are therefore separated by at least one idle cycle.
- Only one bank's csb is ever low, and only during ISSUE.
- Request fields are sampled only in IDLE; changes to mem_* during an access are ignored.
- err stays set until reset. Later out-of-range accesses do not update err_addr.

Test Plan:
- Defaults, write 32'hCAFEBABE to 0x004 with wstrb=4'hF, then read 0x004 → write: sram_csb=2'b10, web=0, addr=1 in cycle 1, mem_ready in cycle 2. Read: mem_ready in cycle 3, rdata=32'hCAFEBABE.
- Bank boundary: read 0x3FC and 0x400 → 0x3FC selects bank 0 with addr=255; 0x400 selects bank 1 with addr=0.
- Byte write to 0x002 with wstrb=4'b0100, data 32'h00AB0000 → sram_wmask=4'b0100, web=0, mem_ready in cycle 2.
- READ_LATENCY=3, BASE_ADDR=32'h1000_0000, read 0x1000_0010 → addr=4, mem_ready in cycle 5; 0x0000_0010 is out of range.
- Out-of-range read 0x0000_0800 (defaults) → mem_ready in cycle 1, rdata=0, err=1, err_addr=0x800. A second bad access at 0x900 leaves err_addr=0x800.
- Reset in cycle 2 of a READ_LATENCY=3 read → no mem_ready pulse, state IDLE, csb all 1, err=0 after reset.

Source files
------------

// File: rtl/picorv32_sram_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : picorv32_sram_bridge                                         |
// | Description : Bridges the picorv32 native memory interface to one or more  |
// |               single-port SRAM macros with active-low controls. Requests   |
// |               outside the SRAM window complete at once with a sticky error |
// |               flag so the core can never stall on a bad address.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module picorv32_sram_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          NUM_BANKS    = 2,
    parameter int          BANK_AW      = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid,
    input  logic                      mem_instr,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [NUM_BANKS-1:0]      sram_csb,
    output logic                      sram_web,
    output logic [3:0]                sram_wmask,
    output logic [BANK_AW-1:0]        sram_addr,
    output logic [31:0]               sram_din,
    input  logic [NUM_BANKS*32-1:0]   sram_dout,
    output logic                      err,
    output logic [31:0]               err_addr
);

    // Bank index width; a single bank still carries a 1-bit (always zero) index.
    localparam int          c_BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    // Window size in bytes, held in 64 bits so large configurations cannot wrap.
    localparam logic [63:0] c_WINDOW_BYTES = 64'(NUM_BANKS) << (BANK_AW + 2);
    localparam logic [1:0]  c_CNT_INIT     = 2'(READ_LATENCY - 1);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_ISSUE = 2'd1;
    localparam logic [1:0]  c_WAIT  = 2'd2;
    localparam logic [1:0]  c_RESP  = 2'd3;

    // Sequential state
    logic [1:0]           r_state;
    logic                 r_mem_ready;
    logic [31:0]          r_mem_rdata;
    logic [NUM_BANKS-1:0] r_csb;
    logic                 r_web;
    logic [3:0]           r_wmask;
    logic [BANK_AW-1:0]   r_saddr;
    logic [31:0]          r_din;
    logic                 r_err;
    logic [31:0]          r_err_addr;
    logic [c_BANK_W-1:0]  r_bank;
    logic                 r_is_write;
    logic [1:0]           r_cnt;

    // Next-state values
    logic [1:0]           w_state_next;
    logic                 w_ready_n;
    logic [31:0]          w_rdata_n;
    logic [NUM_BANKS-1:0] w_csb_n;
    logic                 w_web_n;
    logic [3:0]           w_wmask_n;
    logic [BANK_AW-1:0]   w_saddr_n;
    logic [31:0]          w_din_n;
    logic                 w_err_n;
    logic [31:0]          w_err_addr_n;
    logic [c_BANK_W-1:0]  w_bank_n;
    logic                 w_is_write_n;
    logic [1:0]           w_cnt_n;

    // Address decode
    logic [31:0]          w_off;
    logic                 w_in_range;
    logic [BANK_AW-1:0]   w_word_addr;
    logic [c_BANK_W-1:0]  w_bank;
    logic [NUM_BANKS-1:0] w_bank_sel;
    logic [31:0]          w_dout_bank [NUM_BANKS];
    logic [31:0]          w_dout_sel;
    logic                 w_accept;
    logic                 w_unused_ok;

    assign w_off       = mem_addr - BASE_ADDR;
    assign w_in_range  = (mem_addr >= BASE_ADDR) && ({32'd0, w_off} < c_WINDOW_BYTES);
    assign w_word_addr = w_off[2 +: BANK_AW];
    assign w_accept    = mem_valid && !r_mem_ready;

    generate
        if (NUM_BANKS > 1) begin : g_multi_bank
            assign w_bank     = w_off[2 + BANK_AW +: c_BANK_W];
            assign w_dout_sel = w_dout_bank[r_bank];
        end else begin : g_single_bank
            assign w_bank     = '0;
            assign w_dout_sel = w_dout_bank[0];
        end
    endgenerate

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            localparam logic [c_BANK_W-1:0] c_IDX = c_BANK_W'(g);
            assign w_bank_sel[g]  = (w_bank == c_IDX);
            assign w_dout_bank[g] = sram_dout[32*g +: 32];
        end
    endgenerate

    // Byte lane bits, high offset bits and the fetch hint carry no meaning here.
    assign w_unused_ok = ^{mem_instr, w_off, r_bank};

    // State register and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= 32'd0;
            r_csb       <= '1;
            r_web       <= 1'b1;
            r_wmask     <= 4'd0;
            r_saddr     <= '0;
            r_din       <= 32'd0;
            r_err       <= 1'b0;
            r_err_addr  <= 32'd0;
            r_bank      <= '0;
            r_is_write  <= 1'b0;
            r_cnt       <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_mem_ready <= w_ready_n;
            r_mem_rdata <= w_rdata_n;
            r_csb       <= w_csb_n;
            r_web       <= w_web_n;
            r_wmask     <= w_wmask_n;
            r_saddr     <= w_saddr_n;
            r_din       <= w_din_n;
            r_err       <= w_err_n;
            r_err_addr  <= w_err_addr_n;
            r_bank      <= w_bank_n;
            r_is_write  <= w_is_write_n;
            r_cnt       <= w_cnt_n;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = w_in_range ? c_ISSUE : c_RESP;
            c_ISSUE: w_state_next = r_is_write ? c_RESP : c_WAIT;
            c_WAIT:  if (r_cnt == 2'd0) w_state_next = c_RESP;
            c_RESP:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Next values of the registered outputs and request context
    always_comb begin
        w_ready_n    = 1'b0;
        w_rdata_n    = r_mem_rdata;
        w_csb_n      = '1;
        w_web_n      = 1'b1;
        w_wmask_n    = r_wmask;
        w_saddr_n    = r_saddr;
        w_din_n      = r_din;
        w_err_n      = r_err;
        w_err_addr_n = r_err_addr;
        w_bank_n     = r_bank;
        w_is_write_n = r_is_write;
        w_cnt_n      = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_csb_n      = ~w_bank_sel;
                        w_web_n      = ~|mem_wstrb;
                        w_wmask_n    = mem_wstrb;
                        w_saddr_n    = w_word_addr;
                        w_din_n      = mem_wdata;
                        w_bank_n     = w_bank;
                        w_is_write_n = |mem_wstrb;
                    end else begin
                        // Bad address: answer immediately with zero data.
                        w_ready_n = 1'b1;
                        w_rdata_n = 32'd0;
                        if (!r_err) begin
                            w_err_n      = 1'b1;
                            w_err_addr_n = mem_addr;
                        end
                    end
                end
            end
            c_ISSUE: begin
                if (r_is_write) w_ready_n = 1'b1;
                else            w_cnt_n   = c_CNT_INIT;
            end
            c_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_ready_n = 1'b1;
                    w_rdata_n = w_dout_sel;
                end else begin
                    w_cnt_n = r_cnt - 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign mem_ready  = r_mem_ready;
    assign mem_rdata  = r_mem_rdata;
    assign sram_csb   = r_csb;
    assign sram_web   = r_web;
    assign sram_wmask = r_wmask;
    assign sram_addr  = r_saddr;
    assign sram_din   = r_din;
    assign err        = r_err;
    assign err_addr   = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_sram_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_picorv32_sram_bridge                                      |
// | Description : Scoreboard bench for picorv32_sram_bridge. Instance 0 uses   |
// |               default parameters, instance 1 uses READ_LATENCY=3 and a     |
// |               base address of 0x1000_0000. Each has a behavioural SRAM.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_picorv32_sram_bridge;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        int          cyc;
        logic        err;
        logic [31:0] err_addr;
    } resp_t;

    typedef struct {
        logic [1:0]  csb;
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  saddr;
        logic [31:0] din;
        bit          chk_din;
        int          cyc;
    } sreq_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        valid    [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic [3:0]  wstrb    [2];
    logic        ready    [2];
    logic [31:0] rdata    [2];
    logic [1:0]  csb      [2];
    logic        web      [2];
    logic [3:0]  wmask    [2];
    logic [7:0]  saddr    [2];
    logic [31:0] din      [2];
    logic [63:0] dout     [2];
    logic        err      [2];
    logic [31:0] err_addr [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    resp_t rq0 [$];
    resp_t rq1 [$];
    sreq_t sq0 [$];
    sreq_t sq1 [$];

    always #5 clk = ~clk;

    // Cycle counter; drivers and monitors read it after it settles.
    always @(posedge clk) cyc <= cyc + 1;

    picorv32_sram_bridge u_dut0 (
        .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(1'b0),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .sram_csb(csb[0]),
        .sram_web(web[0]), .sram_wmask(wmask[0]), .sram_addr(saddr[0]),
        .sram_din(din[0]), .sram_dout(dout[0]), .err(err[0]), .err_addr(err_addr[0])
    );

    picorv32_sram_bridge #(
        .BASE_ADDR(32'h1000_0000), .NUM_BANKS(2), .BANK_AW(8), .READ_LATENCY(3)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(1'b0),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .sram_csb(csb[1]),
        .sram_web(web[1]), .sram_wmask(wmask[1]), .sram_addr(saddr[1]),
        .sram_din(din[1]), .sram_dout(dout[1]), .err(err[1]), .err_addr(err_addr[1])
    );

    // Behavioural SRAMs: data is valid only in the exact latency cycle.
    logic [31:0] ma [2][256];
    logic [31:0] mb [2][256];
    logic [31:0] pa [2];
    logic [31:0] pb [2][3];

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!csb[0][b] && !web[0])
                for (int k = 0; k < 4; k++)
                    if (wmask[0][k]) ma[b][saddr[0]][8*k +: 8] <= din[0][8*k +: 8];
            pa[b] <= (!csb[0][b] && web[0]) ? ma[b][saddr[0]] : 32'hDEAD_0000;
            if (!csb[1][b] && !web[1])
                for (int k = 0; k < 4; k++)
                    if (wmask[1][k]) mb[b][saddr[1]][8*k +: 8] <= din[1][8*k +: 8];
            pb[b][0] <= (!csb[1][b] && web[1]) ? mb[b][saddr[1]] : 32'hDEAD_0001;
            pb[b][1] <= pb[b][0];
            pb[b][2] <= pb[b][1];
        end
    end

    assign dout[0] = {pa[1], pa[0]};
    assign dout[1] = {pb[1][2], pb[0][2]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_resp(input int d);
        resp_t r;
        bit    have;
        if (ready[d]) begin
            have = (d == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
            if (!have) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut%0d_unexpected_ready: got ready=1 at cycle %0d expected none", d, cyc);
            end else begin
                if (d == 0) r = rq0.pop_front();
                else        r = rq1.pop_front();
                check($sformatf("dut%0d_ready_cycle", d), cyc, r.cyc);
                if (r.chk_rdata) check($sformatf("dut%0d_rdata", d), rdata[d], r.rdata);
                check($sformatf("dut%0d_err", d), {31'd0, err[d]}, {31'd0, r.err});
                check($sformatf("dut%0d_err_addr", d), err_addr[d], r.err_addr);
            end
        end
    endtask

    task automatic mon_sram(input int d);
        sreq_t s;
        bit    have;
        if (csb[d] != 2'b11) begin
            have = (d == 0) ? (sq0.size() != 0) : (sq1.size() != 0);
            if (!have) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut%0d_unexpected_csb: got csb=%b at cycle %0d expected 11", d, csb[d], cyc);
            end else begin
                if (d == 0) s = sq0.pop_front();
                else        s = sq1.pop_front();
                check($sformatf("dut%0d_csb_cycle", d), cyc, s.cyc);
                check($sformatf("dut%0d_csb", d), {30'd0, csb[d]}, {30'd0, s.csb});
                check($sformatf("dut%0d_web", d), {31'd0, web[d]}, {31'd0, s.web});
                check($sformatf("dut%0d_wmask", d), {28'd0, wmask[d]}, {28'd0, s.wmask});
                check($sformatf("dut%0d_sram_addr", d), {24'd0, saddr[d]}, {24'd0, s.saddr});
                if (s.chk_din) check($sformatf("dut%0d_din", d), din[d], s.din);
            end
        end
    endtask

    // Monitors: compare whatever the DUTs present against the queued expectations.
    always @(negedge clk) begin
        mon_resp(0);
        mon_resp(1);
        mon_sram(0);
        mon_sram(1);
    end

    // One core access; request fields are scrambled after the accept edge.
    task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit in_range, input logic [1:0] ecsb,
                          input logic [7:0] esaddr, input int lat, input logic [31:0] erd,
                          input bit chk_rd, input logic eerr, input logic [31:0] eerr_addr);
        resp_t r;
        sreq_t s;
        bit    seen;
        @(posedge clk); #1;
        valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
        if (in_range) begin
            s.csb = ecsb; s.web = ~|ws; s.wmask = ws; s.saddr = esaddr;
            s.din = wd; s.chk_din = |ws; s.cyc = cyc + 1;
            if (d == 0) sq0.push_back(s);
            else        sq1.push_back(s);
        end
        r.rdata = erd; r.chk_rdata = chk_rd; r.cyc = cyc + lat;
        r.err = eerr; r.err_addr = eerr_addr;
        if (d == 0) rq0.push_back(r);
        else        rq1.push_back(r);
        @(posedge clk); #1;
        addr[d] = a ^ 32'h10; wdata[d] = ~wd; wstrb[d] = ~ws;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready[d]) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("dut%0d_ready_seen_%h", d, a), {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        valid[d] = 1'b0; wstrb[d] = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sreq_t s;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready[0]}, 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_csb", {30'd0, csb[0]}, 32'd3);
        check("rst_web", {31'd0, web[0]}, 32'd1);
        check("rst_wmask", {28'd0, wmask[0]}, 32'd0);
        check("rst_sram_addr", {24'd0, saddr[0]}, 32'd0);
        check("rst_din", din[0], 32'd0);
        check("rst_err", {31'd0, err[0]}, 32'd0);
        check("rst_err_addr", err_addr[0], 32'd0);

        // Default instance: write/read, bank boundary, byte write, bad addresses
        access(0, 32'h004, 32'hCAFEBABE, 4'hF, 1, 2'b10, 8'd1,   2, 32'd0,          0, 1'b0, 32'd0);
        access(0, 32'h004, 32'h0,        4'h0, 1, 2'b10, 8'd1,   3, 32'hCAFEBABE,   1, 1'b0, 32'd0);
        access(0, 32'h3FC, 32'h11111111, 4'hF, 1, 2'b10, 8'd255, 2, 32'd0,          0, 1'b0, 32'd0);
        access(0, 32'h400, 32'h22222222, 4'hF, 1, 2'b01, 8'd0,   2, 32'd0,          0, 1'b0, 32'd0);
        access(0, 32'h3FC, 32'h0,        4'h0, 1, 2'b10, 8'd255, 3, 32'h11111111,   1, 1'b0, 32'd0);
        access(0, 32'h400, 32'h0,        4'h0, 1, 2'b01, 8'd0,   3, 32'h22222222,   1, 1'b0, 32'd0);
        access(0, 32'h000, 32'h12345678, 4'hF, 1, 2'b10, 8'd0,   2, 32'd0,          0, 1'b0, 32'd0);
        access(0, 32'h002, 32'h00AB0000, 4'b0100, 1, 2'b10, 8'd0, 2, 32'd0,         0, 1'b0, 32'd0);
        access(0, 32'h000, 32'h0,        4'h0, 1, 2'b10, 8'd0,   3, 32'h12AB5678,   1, 1'b0, 32'd0);
        access(0, 32'h800, 32'h0,        4'h0, 0, 2'b11, 8'd0,   1, 32'd0,          1, 1'b1, 32'h800);
        access(0, 32'h900, 32'h55555555, 4'hF, 0, 2'b11, 8'd0,   1, 32'd0,          1, 1'b1, 32'h800);
        access(0, 32'h007, 32'h0,        4'h0, 1, 2'b10, 8'd1,   3, 32'hCAFEBABE,   1, 1'b1, 32'h800);

        // Second instance: longer read latency and non-zero base
        access(1, 32'h1000_0010, 32'hDEADBEEF, 4'hF, 1, 2'b10, 8'd4, 2, 32'd0,        0, 1'b0, 32'd0);
        access(1, 32'h1000_0010, 32'h0,        4'h0, 1, 2'b10, 8'd4, 5, 32'hDEADBEEF, 1, 1'b0, 32'd0);
        access(1, 32'h0000_0010, 32'h0,        4'h0, 0, 2'b11, 8'd0, 1, 32'd0,        1, 1'b1, 32'h10);

        // Reset during cycle 2 of a read must abort it silently
        @(posedge clk); #1;
        valid[1] = 1'b1; addr[1] = 32'h1000_0010; wdata[1] = 32'd0; wstrb[1] = 4'd0;
        s.csb = 2'b10; s.web = 1'b1; s.wmask = 4'd0; s.saddr = 8'd4;
        s.din = 32'd0; s.chk_din = 1'b0; s.cyc = cyc + 1;
        sq1.push_back(s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        valid[1] = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, ready[1]}, 32'd0);
        check("abort_csb", {30'd0, csb[1]}, 32'd3);
        check("abort_err", {31'd0, err[1]}, 32'd0);
        check("abort_err_addr", err_addr[1], 32'd0);
        repeat (8) @(posedge clk);
        access(1, 32'h1000_0010, 32'h0, 4'h0, 1, 2'b10, 8'd4, 5, 32'hDEADBEEF, 1, 1'b0, 32'd0);

        repeat (6) @(posedge clk);
        check("dut0_resp_left", rq0.size(), 32'd0);
        check("dut1_resp_left", rq1.size(), 32'd0);
        check("dut0_sram_left", sq0.size(), 32'd0);
        check("dut1_sram_left", sq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
